// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter for the shared crypto operand mux. It grants one requester per
// burst, drives the mux select and passes beats through a registered valid/ready stage.
module operand_mux_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LENW  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*LENW-1:0]   i_req_len,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*WIDTH-1:0]  i_req_data,
    output logic [NREQ-1:0]        o_req_ready_c,
    output logic [NREQ-1:0]        o_gnt,
    output logic [2:0]             o_sel,
    output logic [WIDTH-1:0]       o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_done,
    output logic                   o_abort
);

    localparam int unsigned SELW = 3;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [SELW-1:0]   r_sel;
    logic [SELW-1:0]   r_ptr;
    logic [LENW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_done;
    logic              r_abort;

    state_t            w_state_nxt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [SELW-1:0]   w_sel_nxt;
    logic [SELW-1:0]   w_ptr_nxt;
    logic [LENW-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]  w_out_data_nxt;
    logic              w_out_valid_nxt;
    logic              w_done_nxt;
    logic              w_abort_nxt;

    logic              w_found;
    logic [SELW-1:0]   w_win;
    logic [LENW-1:0]   w_win_len;
    logic              w_req_g;
    logic              w_valid_g;
    logic [WIDTH-1:0]  w_data_g;
    logic              w_accept;
    logic [SELW-1:0]   w_ptr_inc;

    // Winner search: first pass covers indices at or above PTR, second pass wraps to 0.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_win_len = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!w_found && i_req[i] && (SELW'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_win   = SELW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!w_found && i_req[i]) begin
                w_found = 1'b1;
                w_win   = SELW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (SELW'(i) == w_win) begin
                w_win_len = i_req_len[i*LENW +: LENW];
            end
        end
    end

    // Granted requester's signals, selected through the one-hot grant.
    always_comb begin
        w_req_g   = |(i_req & r_gnt);
        w_valid_g = |(i_req_valid & r_gnt);
        w_data_g  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (r_gnt[i]) begin
                w_data_g = i_req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A dropped request blocks acceptance in the same cycle it is seen.
    assign w_accept      = (r_state == S_BURST) && w_req_g && w_valid_g
                           && (!r_out_valid || i_out_ready);
    assign o_req_ready_c = w_accept ? r_gnt : '0;
    assign w_ptr_inc     = (r_sel == SELW'(NREQ - 1)) ? '0 : r_sel + SELW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_done_nxt      = 1'b0;
        w_abort_nxt     = 1'b0;
        w_out_valid_nxt = r_out_valid && !i_out_ready;
        w_out_data_nxt  = r_out_data;

        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_data_g;
        end

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BURST;
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = w_win_len;
                end
            end
            S_BURST: begin
                if (!w_req_g) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_sel_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_abort_nxt = 1'b1;
                end else if (w_accept) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                        w_sel_nxt   = '0;
                        w_ptr_nxt   = w_ptr_inc;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - LENW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_sel       = r_sel;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;
    assign o_abort     = r_abort;

endmodule

// File: tb/tb_operand_mux_arbiter.sv
// Bench for operand_mux_arbiter: directed bursts with a beat scoreboard on the output stage.
module tb_operand_mux_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LENW  = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*LENW-1:0]  req_len;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       gnt;
    logic [2:0]            sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  done;
    logic                  abort;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    logic [23:0] seq [NREQ];

    operand_mux_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_req_len     (req_len),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .o_req_ready_c (req_ready),
        .o_gnt         (gnt),
        .o_sel         (sel),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_done        (done),
        .o_abort       (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each requester presents {index, sequence}; sequence advances on every accepted beat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREQ); i++) seq[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++)
                if (req_ready[i]) seq[i] <= seq[i] + 24'd1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < int'(NREQ); i++)
            req_data[i*WIDTH +: WIDTH] = {8'(i), seq[i]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat(input int r, input int k);
        return {8'(r), seq[r] + 24'(k)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop on each output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b0;
        bit          seen;

        rst_n = 1'b0; req = '0; req_len = '0; req_valid = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",   32'(gnt), 32'd0);
        check("rst_sel",   32'(sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);

        // Single 3-beat burst on requester 2
        tick;
        rst_n = 1'b1;
        req = 4'b0100; req_len[2*LENW +: LENW] = LENW'(2); req_valid = 4'b0100; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(beat(2, k));
        tick;
        check("s1_gnt",  32'(gnt), 32'b0100);
        check("s1_sel",  32'(sel), 32'd2);
        check("s1_done_early", 32'(done), 32'd0);
        tick;
        check("s1_ready", 32'(req_ready), 32'b0100);
        check("s1_valid", 32'(out_valid), 32'd1);
        tick;
        tick;
        check("s1_done",  32'(done), 32'd1);
        check("s1_gnt_clr", 32'(gnt), 32'd0);
        check("s1_ptr",   32'(dut.r_ptr), 32'd3);
        req = '0; req_valid = '0;
        tick;
        check("s1_done_pulse", 32'(done), 32'd0);
        check("s1_valid_drain", 32'(out_valid), 32'd0);
        check("s1_drained", 32'(exp_q.size()), 32'd0);

        // All requesting with single-beat bursts: order 0,1,2,3,0 with an idle cycle between
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        req = 4'b1111; req_len = '0; req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(beat(k % 4, 0));
            tick;
            check("s2_gnt", 32'(gnt), 32'd1 << (k % 4));
            check("s2_sel", 32'(sel), 32'(k % 4));
            tick;
            check("s2_done", 32'(done), 32'd1);
            check("s2_gap",  32'(gnt), 32'd0);
        end
        req = '0; req_valid = '0;
        tick;
        tick;

        // Requester 1, 4 beats, output stalled for three cycles after the first beat
        req = 4'b0010; req_len[1*LENW +: LENW] = LENW'(3); req_valid = 4'b0010; out_ready = 1'b1;
        b0 = beat(1, 0);
        for (int k = 0; k < 4; k++) exp_q.push_back(beat(1, k));
        tick;
        check("s3_gnt", 32'(gnt), 32'b0010);
        tick;
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("s3_stall_ready", 32'(req_ready), 32'd0);
            check("s3_hold_data",   out_data, b0);
            check("s3_hold_valid",  32'(out_valid), 32'd1);
            tick;
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick;
            if (done) seen = 1'b1;
        end
        req = '0; req_valid = '0;
        check("s3_done_seen", 32'(seen), 32'd1);
        tick;
        tick;
        check("s3_drained", 32'(exp_q.size()), 32'd0);

        // Requester 3 with LEN=5 drops its request after 2 beats
        req = 4'b1000; req_len[3*LENW +: LENW] = LENW'(5); req_valid = 4'b1000;
        exp_q.push_back(beat(3, 0));
        exp_q.push_back(beat(3, 1));
        tick;
        check("s4_gnt", 32'(gnt), 32'b1000);
        tick;
        tick;
        req = '0;
        #1;
        check("s4_ready_gated", 32'(req_ready), 32'd0);
        tick;
        check("s4_abort",   32'(abort), 32'd1);
        check("s4_no_done", 32'(done), 32'd0);
        check("s4_gnt_clr", 32'(gnt), 32'd0);
        req = 4'b1010; req_valid = 4'b1010; req_len[1*LENW +: LENW] = '0;
        exp_q.push_back(beat(1, 0));
        tick;
        check("s4_rr_gnt", 32'(gnt), 32'b0010);
        check("s4_abort_pulse", 32'(abort), 32'd0);
        tick;
        check("s4_done", 32'(done), 32'd1);

        // Long burst on requester 0 cut by an asynchronous reset
        req = 4'b0001; req_valid = 4'b0001; req_len[0*LENW +: LENW] = LENW'(7);
        for (int k = 0; k < 8; k++) exp_q.push_back(beat(0, k));
        tick;
        check("s5_gnt", 32'(gnt), 32'b0001);
        tick;
        tick;
        #3;
        rst_n = 1'b0;
        #1;
        check("s5_async_gnt",   32'(gnt), 32'd0);
        check("s5_async_sel",   32'(sel), 32'd0);
        check("s5_async_valid", 32'(out_valid), 32'd0);
        check("s5_async_done",  32'(done), 32'd0);
        exp_q.delete();
        req = '0; req_valid = '0;
        tick;
        tick;
        rst_n = 1'b1;
        req = 4'b1010; req_valid = 4'b1010; req_len[1*LENW +: LENW] = '0;
        exp_q.push_back({8'd1, 24'd0});
        tick;
        check("s5_post_rst_gnt", 32'(gnt), 32'b0010);
        check("s5_post_rst_sel", 32'(sel), 32'd1);
        tick;
        check("s5_done", 32'(done), 32'd1);
        req = '0; req_valid = '0;

        // REQ_LEN raised mid-burst is ignored
        tick;
        req = 4'b0100; req_valid = 4'b0100; req_len[2*LENW +: LENW] = LENW'(1);
        exp_q.push_back(beat(2, 0));
        exp_q.push_back(beat(2, 1));
        tick;
        check("s6_gnt", 32'(gnt), 32'b0100);
        req_len[2*LENW +: LENW] = LENW'(7);
        tick;
        check("s6_not_done", 32'(done), 32'd0);
        tick;
        check("s6_done", 32'(done), 32'd1);
        check("s6_gnt_clr", 32'(gnt), 32'd0);
        req = '0; req_valid = '0;
        tick;
        tick;
        check("s6_valid_drain", 32'(out_valid), 32'd0);
        check("s6_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
